// File: rtl/reg_lock_scoreboard_if.sv
// Issue/write-back bundle between the issue stage and the register-lock scoreboard.
// The issue stage drives through master; the scoreboard answers through slave.
interface reg_lock_scoreboard_if #(
   parameter int NR = 32,
   parameter int NL = 2,
   parameter int NW = 2
);
   localparam int RW = $clog2(NR);

   logic                   flush_i;
   logic [NL-1:0]          pl_valid_i;
   logic [NL-1:0]          blocking_i;
   logic [NL-1:0][RW-1:0]  rd_i;
   logic [NL-1:0][NR-1:0]  reg_req_i;
   logic [NL-1:0]          gnt_o;
   logic [NW-1:0]          wb_valid_i;
   logic [NW-1:0][RW-1:0]  wb_rd_i;
   logic                   blk_done_i;
   logic [NR-1:0]          locks_o;
   logic                   busy_o;

   modport master (
      output flush_i, pl_valid_i, blocking_i, rd_i, reg_req_i,
      output wb_valid_i, wb_rd_i, blk_done_i,
      input  gnt_o, locks_o, busy_o
   );

   modport slave (
      input  flush_i, pl_valid_i, blocking_i, rd_i, reg_req_i,
      input  wb_valid_i, wb_rd_i, blk_done_i,
      output gnt_o, locks_o, busy_o
   );
endinterface

// File: rtl/reg_lock_scoreboard.sv
// Multi-lane in-order register-lock scoreboard with blocking-instruction freeze.
// Define REG_LOCK_CNT_EN for per-register pending-write counters (WAW allowed) instead of lock bits.
module reg_lock_scoreboard #(
   parameter int NR       = 32,
   parameter int NL       = 2,
   parameter int NW       = 2
`ifdef REG_LOCK_CNT_EN
   ,
   parameter int MAX_PEND = 3
`endif
) (
   input  logic                 clk_i,
   input  logic                 arst_i,
   reg_lock_scoreboard_if.slave bus
);
   localparam int RW = $clog2(NR);

   logic [NR-1:0]          w_held;
   logic [NR-1:0]          w_locks;
   logic [NR-1:0]          w_claim;
   logic [NL-1:0]          w_gnt;
   logic                   w_blk_gnt;
   logic                   r_blk;
   logic [NR-1:0][NL-1:0]  w_set_m;
   logic [NR-1:0][NW-1:0]  w_clr_m;

`ifdef REG_LOCK_CNT_EN
   localparam int CW = $clog2(MAX_PEND + 1);
   localparam int IW = $clog2(NL + 1);
   logic [CW-1:0] r_cnt      [NR];
   logic [CW-1:0] w_cnt_next [NR];
   logic [IW-1:0] w_inc      [NR];
`else
   logic [NR-1:0] r_lock;
   logic [NR-1:0] w_lock_next;
`endif

   assign w_locks = r_blk ? '1 : w_held;

   // Lanes are walked oldest first; w_claim collects rds already granted this cycle.
   always_comb begin
      logic ok;
      logic prev;
      w_claim   = '0;
      w_gnt     = '0;
      w_blk_gnt = 1'b0;
      ok        = 1'b0;
      prev      = 1'b1;
`ifdef REG_LOCK_CNT_EN
      for (int r = 0; r < NR; r++) w_inc[r] = '0;
`endif
      for (int k = 0; k < NL; k++) begin
         ok = bus.pl_valid_i[k]
            && ((bus.reg_req_i[k] & w_locks) == '0)
            && ((bus.reg_req_i[k] & w_claim) == '0);
`ifdef REG_LOCK_CNT_EN
         if (bus.rd_i[k] != '0)
            ok = ok && ((int'(r_cnt[bus.rd_i[k]]) + int'(w_inc[bus.rd_i[k]])) < MAX_PEND);
`else
         ok = ok && !w_held[bus.rd_i[k]]
            && !((bus.rd_i[k] != '0) && w_claim[bus.rd_i[k]]);
`endif
         if (bus.blocking_i[k])
            ok = ok && (k == 0) && (w_locks == '0);
         ok = ok && prev && !w_blk_gnt && !r_blk && !bus.flush_i && !arst_i;
         w_gnt[k] = ok;
         if (ok && bus.blocking_i[k])
            w_blk_gnt = 1'b1;
         if (ok && !bus.blocking_i[k] && (bus.rd_i[k] != '0)) begin
            w_claim[bus.rd_i[k]] = 1'b1;
`ifdef REG_LOCK_CNT_EN
            w_inc[bus.rd_i[k]] = w_inc[bus.rd_i[k]] + 1'b1;
`endif
         end
         prev = ok;
      end
   end

   genvar gi, gk, gw;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_reg
         for (gk = 0; gk < NL; gk++) begin : g_set
            assign w_set_m[gi][gk] = w_gnt[gk] && !bus.blocking_i[gk]
                                  && (bus.rd_i[gk] == RW'(gi)) && (gi != 0);
         end
         for (gw = 0; gw < NW; gw++) begin : g_clr
            assign w_clr_m[gi][gw] = bus.wb_valid_i[gw]
                                  && (bus.wb_rd_i[gw] == RW'(gi)) && (gi != 0);
         end
`ifdef REG_LOCK_CNT_EN
         // Retire first (never below zero), then add new writers so a fresh set survives.
         always_comb begin
            int s;
            s = int'(r_cnt[gi]) - $countones(w_clr_m[gi]);
            if (s < 0) s = 0;
            s = s + $countones(w_set_m[gi]);
            if (s > MAX_PEND) s = MAX_PEND;
            w_cnt_next[gi] = CW'(s);
         end
         assign w_held[gi] = (r_cnt[gi] != '0);
`else
         assign w_lock_next[gi] = (|w_set_m[gi]) ? 1'b1 :
                                  (|w_clr_m[gi]) ? 1'b0 : r_lock[gi];
         assign w_held[gi] = r_lock[gi];
`endif
      end
   endgenerate

`ifdef REG_LOCK_CNT_EN
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int r = 0; r < NR; r++) r_cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NR; r++) r_cnt[r] <= bus.flush_i ? '0 : w_cnt_next[r];
      end
   end
`else
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         r_lock <= '0;
      else if (bus.flush_i)
         r_lock <= '0;
      else
         r_lock <= w_lock_next;
   end
`endif

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         r_blk <= 1'b0;
      else if (bus.flush_i)
         r_blk <= 1'b0;
      else if (w_blk_gnt)
         r_blk <= 1'b1;
      else if (bus.blk_done_i)
         r_blk <= 1'b0;
   end

   assign bus.gnt_o   = w_gnt;
   assign bus.locks_o = w_locks;
   assign bus.busy_o  = r_blk;
endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// Directed scoreboard bench for reg_lock_scoreboard (NR=32, NL=2, NW=2).
module tb_reg_lock_scoreboard;
   logic clk;
   logic arst;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string       tag;
      logic [1:0]  gnt;
      logic [31:0] locks;
      logic        busy;
   } exp_t;

   exp_t q[$];

   reg_lock_scoreboard_if #(.NR(32), .NL(2), .NW(2)) bus ();

   reg_lock_scoreboard #(.NR(32), .NL(2), .NW(2)) dut (
      .clk_i  (clk),
      .arst_i (arst),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] b(input int n);
      return 32'(1) << n;
   endfunction

   task automatic idle();
      bus.flush_i    = 1'b0;
      bus.pl_valid_i = '0;
      bus.blocking_i = '0;
      bus.rd_i       = '0;
      bus.reg_req_i  = '0;
      bus.wb_valid_i = '0;
      bus.wb_rd_i    = '0;
      bus.blk_done_i = 1'b0;
   endtask

   task automatic lane(input int k, input logic blk, input logic [4:0] rd, input logic [31:0] req);
      bus.pl_valid_i[k] = 1'b1;
      bus.blocking_i[k] = blk;
      bus.rd_i[k]       = rd;
      bus.reg_req_i[k]  = req;
   endtask

   task automatic wb(input int w, input logic [4:0] rd);
      bus.wb_valid_i[w] = 1'b1;
      bus.wb_rd_i[w]    = rd;
   endtask

   // Push expectation for the inputs just driven, pop and compare mid-cycle, then advance.
   task automatic step(input string tag, input logic [1:0] g, input logic [31:0] l, input logic bz);
      exp_t e;
      exp_t o;
      e.tag = tag; e.gnt = g; e.locks = l; e.busy = bz;
      q.push_back(e);
      @(negedge clk);
      o = q.pop_front();
      checks++;
      assert (bus.gnt_o === o.gnt) else begin
         errors++;
         $error("FAIL %s gnt: observed %b expected %b", o.tag, bus.gnt_o, o.gnt);
      end
      checks++;
      assert (bus.locks_o === o.locks) else begin
         errors++;
         $error("FAIL %s locks: observed %h expected %h", o.tag, bus.locks_o, o.locks);
      end
      checks++;
      assert (bus.busy_o === o.busy) else begin
         errors++;
         $error("FAIL %s busy: observed %b expected %b", o.tag, bus.busy_o, o.busy);
      end
      $display("step %-10s gnt=%b locks=%h busy=%b", o.tag, bus.gnt_o, bus.locks_o, bus.busy_o);
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      logic [31:0] e;
      arst = 1'b0;
      idle();
      #1 arst = 1'b1;

      lane(0, 0, 3, 0);                   step("reset",    2'b00, 0, 0);
      arst = 1'b0;
      lane(0, 0, 5, 0); lane(1, 0, 6, b(5)); step("raw_intra", 2'b01, 0, 0);
                                          step("lock5",    2'b00, b(5), 0);
      wb(0, 5); lane(0, 0, 8, b(5));      step("wb_nobyp", 2'b00, b(5), 0);
      lane(0, 0, 8, b(5));                step("wb_after", 2'b01, 0, 0);
      lane(0, 1, 0, 0); wb(0, 8);         step("blk_wait", 2'b00, b(8), 0);
      lane(0, 1, 0, 0); lane(1, 0, 9, 0); step("blk_gnt",  2'b01, 0, 0);
      lane(0, 0, 10, 0);                  step("busy",     2'b00, 32'hFFFF_FFFF, 1);
      bus.blk_done_i = 1'b1;              step("blk_done", 2'b00, 32'hFFFF_FFFF, 1);
                                          step("unfrozen", 2'b00, 0, 0);
`ifdef REG_LOCK_CNT_EN
      lane(0, 0, 7, 0); lane(1, 0, 7, 0); step("waw_pair", 2'b11, 0, 0);
      lane(0, 0, 7, 0);                   step("waw_3rd",  2'b01, b(7), 0);
      lane(0, 0, 7, 0);                   step("waw_full", 2'b00, b(7), 0);
      lane(0, 0, 7, 0); wb(0, 7);         step("waw_wb",   2'b00, b(7), 0);
      lane(0, 0, 7, 0);                   step("waw_free", 2'b01, b(7), 0);
      e = b(7);
`else
      lane(0, 0, 7, 0); lane(1, 0, 7, 0); step("waw_pair", 2'b01, 0, 0);
      lane(0, 0, 11, 0); lane(1, 0, 7, 0); step("waw_held", 2'b01, b(7), 0);
      e = b(7) | b(11);
`endif
      lane(0, 0, 13, 0); wb(0, 13); wb(1, 13); step("set_wins", 2'b01, e, 0);
      bus.flush_i = 1'b1; lane(0, 0, 20, 0);  step("flush",    2'b00, e | b(13), 0);
                                          step("flushed",  2'b00, 0, 0);
      lane(0, 1, 0, 0);                   step("blk_gnt2", 2'b01, 0, 0);
      bus.flush_i = 1'b1;                 step("flush_bz", 2'b00, 32'hFFFF_FFFF, 1);
                                          step("flushed2", 2'b00, 0, 0);
      lane(0, 0, 0, 0); lane(1, 0, 0, 0); step("r0_pair",  2'b11, 0, 0);
      lane(0, 0, 14, 0);                  step("r0_clean", 2'b01, 0, 0);
      arst = 1'b1; lane(0, 0, 15, 0);     step("mid_rst",  2'b00, 0, 0);
      arst = 1'b0; lane(0, 0, 15, 0);     step("post_rst", 2'b01, 0, 0);
                                          step("lock15",   2'b00, b(15), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
